pe_row_mac: RTL and testbench
=============================

PE_ROW_MAC -- requirements
Module: pe_row_mac

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports are named clk and reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 start  in  1  pulse that begins a new 3-row kernel pass.
REQ-005 mode  in  1  0 = activation-sparse, 1 = weight-sparse; sampled on start.
REQ-006 en  in  1  operand valid from the memory controller.
REQ-007 parallel_out  in  72  nine signed 8-bit weights; weight (r,t) occupies bits [8*(3r+t)+7 : 8*(3r+t)].
REQ-008 serial_out  in  8  signed nonzero activation.
REQ-009 act_index  in  4  activation column c, range 0..15.
REQ-010 wei_index  in  2  kernel column t, range 0..2; used in mode 1 only.
REQ-011 row_val_num  in  4  number of nonzero activations in the row, minus 1.
REQ-012 zero_flag  in  1  with en: the row (mode 0) or pass (mode 1) is empty.
REQ-013 ready  out  1  high in ACC state only.
REQ-014 row_finish_done  out  1  one-cycle pulse at the end of each operand pass.
REQ-015 row_cal_done  out  1  one-cycle pulse with the last drained psum.
REQ-016 psum_valid  out  1  psum_data is valid.
REQ-017 psum_col  out  4  output column, range 0..13.
REQ-018 psum_data  out  20  signed partial sum.

Function
REQ-019 SHALL implement states IDLE, ACC and DRAIN. start moves any state to ACC: it clears all psums, the operand counter and kr (the kernel row), and latches mode.
REQ-020 SHALL accept an operand only when en && ready; en in IDLE or DRAIN is ignored.
REQ-021 Mode 0: each accepted operand (a, c) SHALL add a*w(kr,t) to psum[c-t] for t = 0..2, only where 0 <= c-t <= 13. This is three MACs in the same cycle.
REQ-022 Mode 1: each accepted operand (a, c, t = wei_index) SHALL add a*w(kr,t) to psum[c-t], only if 0 <= c-t <= 13.
REQ-023 Products SHALL be signed 8x8 -> 16 bit, sign-extended to 20 bits. The sum cannot overflow, because each psum gets at most 3 products per row.
REQ-024 Each pass SHALL end when the operand counter reaches row_val_num+1, or on en with zero_flag=1 (no accumulate).
REQ-025 At the end of each pass, row_finish_done SHALL pulse in the cycle after the last accepted operand, and the counter SHALL clear.
REQ-026 Mode 0: the row ends after 1 pass. Mode 1: the row ends after the pass whose wei_index = 2. The controller issues passes for t = 0, 1, 2 in that order.
REQ-027 At row end, the block SHALL enter DRAIN in the same cycle as the row_finish_done pulse.
REQ-028 In DRAIN, the block SHALL emit psum[0..13] on 14 consecutive cycles, with psum_valid=1 and psum_col counting up.
REQ-029 row_cal_done SHALL pulse with psum_col = 13.
REQ-030 On the cycle after psum_col = 13, the block SHALL clear psums, set kr = (kr==2) ? 0 : kr+1, and return to ACC.
REQ-031 Latency: the first psum_valid appears 2 cycles after the last accepted operand.
REQ-032 start together with en: start wins, and the operand is dropped.
REQ-033 start during DRAIN SHALL abort the drain with no row_cal_done.
REQ-034 row_val_num = 15 SHALL be handled as 16 operands; the counter is 5 bits.

Reset
REQ-035 On reset, the block SHALL be in IDLE with kr=0, the counter at 0, psums at 0, and mode at 0.
REQ-036 On reset, the outputs ready, row_finish_done, row_cal_done and psum_valid SHALL be 0, and psum_col and psum_data SHALL be 0.
REQ-037 Reset asserted mid-row SHALL discard all partial state immediately; no pulses are emitted.

Structure
REQ-038 Shared package cnnpr_pkg SHALL hold:
- DATA_WIDTH=8, IF_WIDTH=16, KERNEL_WIDTH=3, OUT_WIDTH=14, PSUM_WIDTH=20;
- the state encoding.
REQ-039 SHALL instantiate pe_mac_lane three times. Each lane does a signed multiply plus a column-range check (c-t in 0..13) and produces the target column and an enable.

Verification
REQ-040 Mode 0, all weights 1, row of act 2 at c=0..15 (row_val_num=15) -> psum[0..13] = 6 each; row_cal_done pulses once.
REQ-041 Mode 0, single act 5 at c=0, w(0,0)=3 -> psum[0]=15, all others 0; act at c=15 contributes only via t=2 to psum[13].
REQ-042 Mode 1, three passes, act -128 at c=7, w(0,t)=-128 -> psum[7], psum[6] and psum[5] each = 16384; row_finish_done pulses 3 times.
REQ-043 zero_flag row in mode 0 -> row_finish_done, then 14 zero psums; a 4th row wraps kr back to 0.
REQ-044 start pulsed mid-DRAIN, and reset asserted mid-ACC -> no row_cal_done; outputs return to their reset values.

Source files
------------

// File: rtl/cnnpr_pkg.sv
// Shared sizing, state encoding and weight-selection helper for the PE row MAC.
package cnnpr_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int IF_WIDTH     = 16;
  localparam int KERNEL_WIDTH = 3;
  localparam int OUT_WIDTH    = 14;
  localparam int PSUM_WIDTH   = 20;
  localparam int COL_W        = $clog2(IF_WIDTH);
  localparam int WEIGHT_BITS  = KERNEL_WIDTH * KERNEL_WIDTH * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Weight (r,t) sits at byte index 3r+t of the packed kernel.
  function automatic logic [DATA_WIDTH-1:0] kernel_weight(
    input logic [WEIGHT_BITS-1:0] w,
    input logic [1:0]             kr,
    input int                     t
  );
    return w[DATA_WIDTH*(KERNEL_WIDTH*int'(kr) + t) +: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// One kernel-column lane: signed 8x8 product plus the target psum column and
// a flag saying whether that column falls inside the output row.
module pe_mac_lane
  import cnnpr_pkg::*;
#(
  parameter int LANE_T = 0
) (
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_act,
  input  logic [DATA_WIDTH-1:0] i_weight,
  input  logic [COL_W-1:0]      i_act_index,
  output logic                  o_en,
  output logic [COL_W-1:0]      o_col,
  output logic [PSUM_WIDTH-1:0] o_prod
);

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic                           w_in_range;

  assign w_prod = $signed(i_act) * $signed(i_weight);
  assign o_prod = {{(PSUM_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

  // c-t is checked unsigned: c >= t rules out negative columns first.
  assign o_col      = i_act_index - COL_W'(LANE_T);
  assign w_in_range = (i_act_index >= COL_W'(LANE_T)) && (o_col <= COL_W'(OUT_WIDTH-1));
  assign o_en       = i_en && w_in_range;

endmodule

// File: rtl/pe_row_mac.sv
// Row processing element: accumulates sparse activation x kernel-row products
// into 14 partial sums, then drains them one column per cycle.
module pe_row_mac
  import cnnpr_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   en,
  input  logic [WEIGHT_BITS-1:0] parallel_out,
  input  logic [DATA_WIDTH-1:0]  serial_out,
  input  logic [COL_W-1:0]       act_index,
  input  logic [1:0]             wei_index,
  input  logic [COL_W-1:0]       row_val_num,
  input  logic                   zero_flag,
  output logic                   ready,
  output logic                   row_finish_done,
  output logic                   row_cal_done,
  output logic                   psum_valid,
  output logic [COL_W-1:0]       psum_col,
  output logic [PSUM_WIDTH-1:0]  psum_data
);

  state_e r_state, w_state_nxt;

  logic                         r_mode;
  logic [1:0]                   r_kr;
  logic [COL_W:0]               r_cnt;
  logic [COL_W-1:0]             r_drain_idx;
  logic signed [PSUM_WIDTH-1:0] r_psum [OUT_WIDTH];
  logic signed [PSUM_WIDTH-1:0] w_psum_add [OUT_WIDTH];

  logic                  r_row_finish_done, r_row_cal_done, r_psum_valid;
  logic [COL_W-1:0]      r_psum_col;
  logic [PSUM_WIDTH-1:0] r_psum_data;

  logic w_accept, w_pass_end, w_row_end, w_drain_emit, w_drain_last;

  logic [KERNEL_WIDTH-1:0] w_lane_en;
  logic [COL_W-1:0]        w_lane_col  [KERNEL_WIDTH];
  logic [PSUM_WIDTH-1:0]   w_lane_prod [KERNEL_WIDTH];

  assign w_accept     = en && (r_state == S_ACC) && !start;
  assign w_pass_end   = w_accept && (zero_flag || (r_cnt == {1'b0, row_val_num}));
  assign w_row_end    = w_pass_end && (!r_mode || (wei_index == 2'd2));
  assign w_drain_emit = (r_state == S_DRAIN) && (r_drain_idx < COL_W'(OUT_WIDTH));
  assign w_drain_last = (r_state == S_DRAIN) && (r_drain_idx == COL_W'(OUT_WIDTH));

  for (genvar k = 0; k < KERNEL_WIDTH; k++) begin : g_lane
    logic w_sel;
    // Weight-sparse mode drives only the lane matching the presented kernel column.
    assign w_sel = w_accept && !zero_flag && (!r_mode || (wei_index == 2'(k)));

    pe_mac_lane #(.LANE_T(k)) u_lane (
      .i_en        (w_sel),
      .i_act       (serial_out),
      .i_weight    (kernel_weight(parallel_out, r_kr, k)),
      .i_act_index (act_index),
      .o_en        (w_lane_en[k]),
      .o_col       (w_lane_col[k]),
      .o_prod      (w_lane_prod[k])
    );
  end

  // Lane columns are c, c-1, c-2, so the three lanes never hit the same psum.
  always_comb begin
    for (int j = 0; j < OUT_WIDTH; j++) w_psum_add[j] = '0;
    for (int k = 0; k < KERNEL_WIDTH; k++) begin
      if (w_lane_en[k]) w_psum_add[w_lane_col[k]] = w_lane_prod[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: assigning the hold value first keeps this block free of latches.
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = S_ACC;
    end else begin
      case (r_state)
        S_ACC:   if (w_row_end)    w_state_nxt = S_DRAIN;
        S_DRAIN: if (w_drain_last) w_state_nxt = S_ACC;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode            <= 1'b0;
      r_kr              <= '0;
      r_cnt             <= '0;
      r_drain_idx       <= '0;
      // NOTE: the psum array is reset so that an aborted row leaves nothing behind.
      for (int j = 0; j < OUT_WIDTH; j++) r_psum[j] <= '0;
      r_row_finish_done <= 1'b0;
      r_row_cal_done    <= 1'b0;
      r_psum_valid      <= 1'b0;
      r_psum_col        <= '0;
      r_psum_data       <= '0;
    end else begin
      r_row_finish_done <= w_pass_end;
      r_row_cal_done    <= 1'b0;
      r_psum_valid      <= 1'b0;
      r_psum_col        <= '0;
      r_psum_data       <= '0;
      if (start) begin
        r_mode      <= mode;
        r_kr        <= '0;
        r_cnt       <= '0;
        r_drain_idx <= '0;
        for (int j = 0; j < OUT_WIDTH; j++) r_psum[j] <= '0;
      end else begin
        if (w_pass_end)    r_cnt <= '0;
        else if (w_accept) r_cnt <= r_cnt + 1'b1;

        if (w_drain_emit) begin
          r_psum_valid   <= 1'b1;
          r_psum_col     <= r_drain_idx;
          r_psum_data    <= r_psum[r_drain_idx];
          r_row_cal_done <= (r_drain_idx == COL_W'(OUT_WIDTH-1));
          r_drain_idx    <= r_drain_idx + 1'b1;
        end else if (w_drain_last) begin
          r_drain_idx <= '0;
          r_kr        <= (r_kr == 2'd2) ? 2'd0 : r_kr + 2'd1;
          for (int j = 0; j < OUT_WIDTH; j++) r_psum[j] <= '0;
        end else begin
          for (int j = 0; j < OUT_WIDTH; j++) r_psum[j] <= r_psum[j] + w_psum_add[j];
        end
      end
    end
  end

  assign ready           = (r_state == S_ACC);
  assign row_finish_done = r_row_finish_done;
  assign row_cal_done    = r_row_cal_done;
  assign psum_valid      = r_psum_valid;
  assign psum_col        = r_psum_col;
  assign psum_data       = r_psum_data;

endmodule

// File: tb/tb_pe_row_mac.sv
// Scoreboard bench for pe_row_mac: a spec-level model predicts drained psums,
// a negedge monitor compares whatever the DUT presents.
module tb_pe_row_mac;

  logic        clk = 1'b0;
  logic        reset, start, mode, en, zero_flag;
  logic [71:0] parallel_out;
  logic [7:0]  serial_out;
  logic [3:0]  act_index, row_val_num;
  logic [1:0]  wei_index;
  logic        ready, row_finish_done, row_cal_done, psum_valid;
  logic [3:0]  psum_col;
  logic [19:0] psum_data;

  pe_row_mac dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .en(en),
    .parallel_out(parallel_out), .serial_out(serial_out), .act_index(act_index),
    .wei_index(wei_index), .row_val_num(row_val_num), .zero_flag(zero_flag),
    .ready(ready), .row_finish_done(row_finish_done), .row_cal_done(row_cal_done),
    .psum_valid(psum_valid), .psum_col(psum_col), .psum_data(psum_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int col;
    int data;
    int last;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0;
  int   wts [3][3];
  int   m_psum [14];
  int   m_kr = 0, m_cnt = 0;
  bit   m_mode = 0;
  int   exp_rfd = 0, exp_rcd = 0, seen_rfd = 0, seen_rcd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (row_finish_done === 1'b1) seen_rfd++;
      if (row_cal_done === 1'b1) seen_rcd++;
      if (psum_valid !== 1'b0) begin
        if (sb_q.size() == 0) begin
          check("psum_valid_unexpected", psum_valid, 0);
        end else begin
          e = sb_q.pop_front();
          check("psum_col", psum_col, e.col);
          check("psum_data", $signed(psum_data), e.data);
          check("row_cal_done_with_col", row_cal_done, e.last);
          if (e.cyc >= 0) check("drain_latency", cyc, e.cyc);
        end
      end
    end
  end

  function automatic logic [71:0] pack_w();
    logic [71:0] w;
    logic [7:0]  b;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int t = 0; t < 3; t++) begin
        b = wts[r][t][7:0];
        w[8*(3*r+t) +: 8] = b;
      end
    return w;
  endfunction

  task automatic rand_w();
    for (int r = 0; r < 3; r++)
      for (int t = 0; t < 3; t++) wts[r][t] = int'($urandom_range(0, 255)) - 128;
  endtask

  function automatic int rand_act();
    int a;
    do a = int'($urandom_range(0, 255)) - 128; while (a == 0);
    return a;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < 14; j++) m_psum[j] = 0;
  endtask

  // Spec-level reference: accumulate by the c-t rule, count operands, close
  // passes and rows, and queue the 14 expected drain beats at row end.
  task automatic model_op(input int a, input int c, input int t, input int rvn, input bit zf,
                          input int dcyc, output bit pend, output bit rend);
    exp_t e;
    pend = zf;
    if (!zf) begin
      for (int k = 0; k < 3; k++) begin
        if (!m_mode || k == t) begin
          int col;
          col = c - k;
          if (col >= 0 && col <= 13) m_psum[col] += a * wts[m_kr][k];
        end
      end
      m_cnt++;
      if (m_cnt == rvn + 1) pend = 1;
    end
    rend = 0;
    if (pend) begin
      m_cnt = 0;
      exp_rfd++;
      rend = !m_mode || (t == 2);
    end
    if (rend) begin
      for (int j = 0; j < 14; j++) begin
        e.col = j; e.data = m_psum[j]; e.last = (j == 13); e.cyc = (j == 0) ? dcyc + 2 : -1;
        sb_q.push_back(e);
      end
      exp_rcd++;
      model_clear();
      m_kr = (m_kr == 2) ? 0 : m_kr + 1;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (ready !== 1'b1) check("ready_timeout", ready, 1);
  endtask

  task automatic send_op(input int a, input int c, input int t, input int rvn, input bit zf);
    bit pend, rend;
    wait_ready();
    parallel_out = pack_w();
    serial_out   = a[7:0];
    act_index    = c[3:0];
    wei_index    = t[1:0];
    row_val_num  = rvn[3:0];
    zero_flag    = zf;
    en           = 1'b1;
    model_op(a, c, t, rvn, zf, cyc, pend, rend);
    @(negedge clk);
    en        = 1'b0;
    zero_flag = 1'b0;
    check("row_finish_done", row_finish_done, pend);
    if (rend) check("ready_low_in_drain", ready, 0);
  endtask

  task automatic shuffle(output int p [16]);
    int j, tmp;
    for (int i = 0; i < 16; i++) p[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = p[i]; p[i] = p[j]; p[j] = tmp;
    end
  endtask

  task automatic do_pass(input int t, input int rvn, input bit zf);
    int pool [16];
    if (zf) begin
      send_op(rand_act(), int'($urandom_range(0, 15)), t, rvn, 1'b1);
    end else begin
      shuffle(pool);
      for (int i = 0; i <= rvn; i++) send_op(rand_act(), pool[i], t, rvn, 1'b0);
    end
  endtask

  task automatic random_row();
    rand_w();
    if (!m_mode) begin
      do_pass(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
    end else begin
      for (int t = 0; t < 3; t++)
        do_pass(t, int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 100) begin @(negedge clk); n++; end
    check("drain_complete", sb_q.size(), 0);
  endtask

  // Optionally drives a would-be pass-ending operand alongside start; start must win.
  task automatic do_start(input bit md, input bit with_en);
    start = 1'b1;
    mode  = md;
    if (with_en) begin
      en = 1'b1; serial_out = 8'd9; act_index = 4'd3; row_val_num = 4'd0; zero_flag = 1'b0;
      parallel_out = pack_w();
    end
    @(negedge clk);
    start = 1'b0;
    en    = 1'b0;
    sb_q.delete();
    m_mode = md; m_kr = 0; m_cnt = 0;
    model_clear();
    check("start_ready", ready, 1);
    check("start_no_row_finish", row_finish_done, 0);
    check("start_psum_valid", psum_valid, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; en = 1'b0; zero_flag = 1'b0;
    parallel_out = '0; serial_out = '0; act_index = '0; wei_index = '0; row_val_num = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_row_finish_done", row_finish_done, 0);
    check("rst_row_cal_done", row_cal_done, 0);
    check("rst_psum_valid", psum_valid, 0);
    check("rst_psum_col", psum_col, 0);
    check("rst_psum_data", psum_data, 0);
    reset = 1'b0;
    @(negedge clk);
    en = 1'b1; row_val_num = 4'd0; serial_out = 8'd1;
    @(negedge clk);
    en = 1'b0;
    check("idle_en_ignored", row_finish_done, 0);
    check("idle_not_ready", ready, 0);

    // All-ones kernel, act 2 at every column: each psum collects three products.
    do_start(1'b0, 1'b0);
    for (int r = 0; r < 3; r++) for (int t = 0; t < 3; t++) wts[r][t] = 1;
    for (int c = 0; c < 16; c++) send_op(2, c, 0, 15, 1'b0);
    wait_drain();

    // Single-operand rows at both column edges; start with a simultaneous en.
    rand_w();
    wts[0][0] = 3;
    do_start(1'b0, 1'b1);
    send_op(5, 0, 0, 0, 1'b0);
    wait_drain();
    send_op(rand_act(), 15, 0, 0, 1'b0);
    wait_drain();

    // Weight-sparse passes t=0,1,2 with extreme negative operands.
    do_start(1'b1, 1'b0);
    for (int t = 0; t < 3; t++) wts[0][t] = -128;
    for (int t = 0; t < 3; t++) send_op(-128, 7, t, 0, 1'b0);
    wait_drain();

    // Empty row then three more rows so kr wraps back to 0.
    do_start(1'b0, 1'b0);
    rand_w();
    do_pass(0, 3, 1'b1);
    wait_drain();
    for (int i = 0; i < 3; i++) begin random_row(); wait_drain(); end

    for (int s = 0; s < 6; s++) begin
      do_start(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++) begin random_row(); wait_drain(); end
    end

    // Start arriving mid-drain aborts it without row_cal_done.
    do_start(1'b0, 1'b0);
    random_row();
    begin
      int n = 0;
      while (!(psum_valid === 1'b1 && psum_col == 4'd5) && n < 50) begin @(negedge clk); n++; end
      check("abort_reached_col5", psum_col, 5);
    end
    exp_rcd--;
    do_start(1'b0, 1'b0);
    check("abort_psum_col", psum_col, 0);
    check("abort_psum_data", psum_data, 0);
    check("abort_row_cal_done", row_cal_done, 0);
    random_row();
    wait_drain();

    // Reset mid-accumulation drops everything and returns to IDLE.
    do_start(1'b1, 1'b0);
    rand_w();
    for (int i = 0; i < 3; i++) send_op(rand_act(), 4 + i, 0, 10, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_ready", ready, 0);
    check("midrst_row_finish_done", row_finish_done, 0);
    check("midrst_psum_valid", psum_valid, 0);
    check("midrst_row_cal_done", row_cal_done, 0);
    m_kr = 0; m_cnt = 0; m_mode = 0; model_clear();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_idle", ready, 0);
    do_start(1'b0, 1'b0);
    random_row();
    wait_drain();
    repeat (3) @(negedge clk);

    check("row_finish_done_count", seen_rfd, exp_rfd);
    check("row_cal_done_count", seen_rcd, exp_rcd);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
